// File: rtl/bp_fe_dual_fetch_buffer_pkg.sv
// ============================================================================
// Module   : bp_fe_dual_fetch_buffer_pkg
// Brief    : Core config, front-end widths and the fetch-entry struct macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BP_FE_FETCH_ENTRY_S_DEFINED
`define BP_FE_FETCH_ENTRY_S_DEFINED
`define BP_FE_FETCH_ENTRY_S(vaddr_w, instr_w, meta_w) \
    typedef struct packed { \
        logic [vaddr_w-1:0] pc; \
        logic [instr_w-1:0] instr; \
        logic               exc; \
        logic [meta_w-1:0]  metadata; \
    } bp_fe_fetch_entry_s
`endif

package bp_fe_dual_fetch_buffer_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int instr_width_gp = 32;

    function automatic int bp_vaddr_width_f(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    function automatic int bp_branch_metadata_width_f(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 36;
            default:          return 36;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_fe_fetch_buffer_ptr.sv
// ============================================================================
// Module   : bp_fe_fetch_buffer_ptr
// Brief    : Read/write pointers and occupancy count for the dual fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_fetch_buffer_ptr
    import bp_fe_dual_fetch_buffer_pkg::*;
#(
    parameter  int depth_p      = 4,
    localparam int ptr_width_lp = $clog2(depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    flush_i,
    input  logic [1:0]              enq_cnt_i,
    input  logic [1:0]              deq_cnt_i,
    output logic [ptr_width_lp-1:0] wr_ptr_o,
    output logic [ptr_width_lp-1:0] rd_ptr_o,
    output logic [ptr_width_lp:0]   count_o
);

    logic [ptr_width_lp-1:0] r_wr_ptr;
    logic [ptr_width_lp-1:0] r_rd_ptr;
    logic [ptr_width_lp:0]   r_count;

    // Pointers are exactly log2(depth) wide so wrap-around is free.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ptr_width_lp'(enq_cnt_i);
            r_rd_ptr <= r_rd_ptr + ptr_width_lp'(deq_cnt_i);
            r_count  <= r_count + (ptr_width_lp+1)'(enq_cnt_i)
                                - (ptr_width_lp+1)'(deq_cnt_i);
        end
    end

    assign wr_ptr_o = r_wr_ptr;
    assign rd_ptr_o = r_rd_ptr;
    assign count_o  = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_fe_dual_fetch_buffer.sv
// ============================================================================
// Module   : bp_fe_dual_fetch_buffer
// Brief    : Two-in/two-out fetch queue between IF2 and the backend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_dual_fetch_buffer
    import bp_fe_dual_fetch_buffer_pkg::*;
#(
    parameter  bp_params_e bp_params_p                 = e_bp_default_cfg,
    parameter  int         depth_p                     = 4,
    localparam int         vaddr_width_p               = bp_vaddr_width_f(bp_params_p),
    localparam int         branch_metadata_fwd_width_p = bp_branch_metadata_width_f(bp_params_p),
    localparam int         ptr_width_lp                = $clog2(depth_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   flush_i,
    input  logic                                   enq_v_i1,
    input  logic                                   enq_v_i2,
    input  logic [vaddr_width_p-1:0]               enq_pc_i1,
    input  logic [vaddr_width_p-1:0]               enq_pc_i2,
    input  logic [instr_width_gp-1:0]              enq_instr_i1,
    input  logic [instr_width_gp-1:0]              enq_instr_i2,
    input  logic                                   enq_exc_i1,
    input  logic                                   enq_exc_i2,
    input  logic                                   enq_path_i,
    input  logic                                   enq_kill_i,
    input  logic [branch_metadata_fwd_width_p-1:0] enq_metadata_i,
    output logic                                   enq_ready_o,
    output logic                                   deq_v_o1,
    output logic                                   deq_v_o2,
    output logic [vaddr_width_p-1:0]               deq_pc_o1,
    output logic [vaddr_width_p-1:0]               deq_pc_o2,
    output logic [instr_width_gp-1:0]              deq_instr_o1,
    output logic [instr_width_gp-1:0]              deq_instr_o2,
    output logic                                   deq_exc_o1,
    output logic                                   deq_exc_o2,
    output logic [branch_metadata_fwd_width_p-1:0] deq_metadata_o1,
    output logic [branch_metadata_fwd_width_p-1:0] deq_metadata_o2,
    input  logic                                   deq_yumi_i1,
    input  logic                                   deq_yumi_i2
);

    `BP_FE_FETCH_ENTRY_S(vaddr_width_p, instr_width_gp, branch_metadata_fwd_width_p);

    if (depth_p < 2 || (depth_p & (depth_p - 1)) != 0) begin : g_bad_depth
        $error("bp_fe_dual_fetch_buffer: depth_p must be a power of two >= 2");
    end

    logic [ptr_width_lp-1:0] w_wr_ptr;
    logic [ptr_width_lp-1:0] w_rd_ptr;
    logic [ptr_width_lp:0]   w_count;
    logic [1:0]              w_enq_cnt;
    logic [1:0]              w_deq_cnt;
    bp_fe_fetch_entry_s      w_slot1;
    bp_fe_fetch_entry_s      w_slot2;
    bp_fe_fetch_entry_s      w_head1;
    bp_fe_fetch_entry_s      w_head2;
    bp_fe_fetch_entry_s      r_mem [depth_p];

    // Ready looks only at registered occupancy: no credit for a same-cycle dequeue.
    assign enq_ready_o = (w_count <= (ptr_width_lp+1)'(depth_p - 2));

    always_comb begin
        w_enq_cnt = 2'd0;
        if (reset_n_i && !flush_i && !enq_kill_i && enq_ready_o && enq_v_i1) begin
            w_enq_cnt = (!enq_v_i2 || enq_exc_i1 || enq_path_i) ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        w_deq_cnt = 2'd0;
        if (reset_n_i && deq_yumi_i1) begin
            w_deq_cnt = deq_yumi_i2 ? 2'd2 : 2'd1;
        end
    end

    bp_fe_fetch_buffer_ptr #(
        .depth_p (depth_p)
    ) u_ptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .enq_cnt_i (w_enq_cnt),
        .deq_cnt_i (w_deq_cnt),
        .wr_ptr_o  (w_wr_ptr),
        .rd_ptr_o  (w_rd_ptr),
        .count_o   (w_count)
    );

    assign w_slot1 = '{pc: enq_pc_i1, instr: enq_instr_i1, exc: enq_exc_i1, metadata: enq_metadata_i};
    assign w_slot2 = '{pc: enq_pc_i2, instr: enq_instr_i2, exc: enq_exc_i2, metadata: enq_metadata_i};

    // Storage is deliberately left unreset; validity comes from the count alone.
    always_ff @(posedge clk_i) begin
        if (w_enq_cnt != 2'd0) begin
            r_mem[w_wr_ptr] <= w_slot1;
        end
        if (w_enq_cnt == 2'd2) begin
            r_mem[w_wr_ptr + ptr_width_lp'(1)] <= w_slot2;
        end
    end

    assign w_head1 = r_mem[w_rd_ptr];
    assign w_head2 = r_mem[w_rd_ptr + ptr_width_lp'(1)];

    assign deq_v_o1        = (w_count >= (ptr_width_lp+1)'(1));
    assign deq_v_o2        = (w_count >= (ptr_width_lp+1)'(2));
    assign deq_pc_o1       = w_head1.pc;
    assign deq_pc_o2       = w_head2.pc;
    assign deq_instr_o1    = w_head1.instr;
    assign deq_instr_o2    = w_head2.instr;
    assign deq_exc_o1      = w_head1.exc;
    assign deq_exc_o2      = w_head2.exc;
    assign deq_metadata_o1 = w_head1.metadata;
    assign deq_metadata_o2 = w_head2.metadata;

    a_yumi1_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq_yumi_i1 |-> deq_v_o1);
    a_yumi2_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (deq_yumi_i1 && deq_yumi_i2) |-> deq_v_o2);

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_dual_fetch_buffer.sv
// ============================================================================
// Module   : tb_bp_fe_dual_fetch_buffer
// Brief    : Directed scoreboard bench for the dual fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_fe_dual_fetch_buffer;
    import bp_fe_dual_fetch_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int VW    = bp_vaddr_width_f(e_bp_default_cfg);
    localparam int IW    = instr_width_gp;
    localparam int MW    = bp_branch_metadata_width_f(e_bp_default_cfg);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          flush_i;
    logic          enq_v_i1, enq_v_i2;
    logic [VW-1:0] enq_pc_i1, enq_pc_i2;
    logic [IW-1:0] enq_instr_i1, enq_instr_i2;
    logic          enq_exc_i1, enq_exc_i2;
    logic          enq_path_i, enq_kill_i;
    logic [MW-1:0] enq_metadata_i;
    logic          enq_ready_o;
    logic          deq_v_o1, deq_v_o2;
    logic [VW-1:0] deq_pc_o1, deq_pc_o2;
    logic [IW-1:0] deq_instr_o1, deq_instr_o2;
    logic          deq_exc_o1, deq_exc_o2;
    logic [MW-1:0] deq_metadata_o1, deq_metadata_o2;
    logic          deq_yumi_i1, deq_yumi_i2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        logic          exc;
        logic [MW-1:0] meta;
    } ent_t;

    ent_t q[$];

    always #5 clk_i = ~clk_i;

    bp_fe_dual_fetch_buffer #(
        .bp_params_p (e_bp_default_cfg),
        .depth_p     (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .flush_i         (flush_i),
        .enq_v_i1        (enq_v_i1),
        .enq_v_i2        (enq_v_i2),
        .enq_pc_i1       (enq_pc_i1),
        .enq_pc_i2       (enq_pc_i2),
        .enq_instr_i1    (enq_instr_i1),
        .enq_instr_i2    (enq_instr_i2),
        .enq_exc_i1      (enq_exc_i1),
        .enq_exc_i2      (enq_exc_i2),
        .enq_path_i      (enq_path_i),
        .enq_kill_i      (enq_kill_i),
        .enq_metadata_i  (enq_metadata_i),
        .enq_ready_o     (enq_ready_o),
        .deq_v_o1        (deq_v_o1),
        .deq_v_o2        (deq_v_o2),
        .deq_pc_o1       (deq_pc_o1),
        .deq_pc_o2       (deq_pc_o2),
        .deq_instr_o1    (deq_instr_o1),
        .deq_instr_o2    (deq_instr_o2),
        .deq_exc_o1      (deq_exc_o1),
        .deq_exc_o2      (deq_exc_o2),
        .deq_metadata_o1 (deq_metadata_o1),
        .deq_metadata_o2 (deq_metadata_o2),
        .deq_yumi_i1     (deq_yumi_i1),
        .deq_yumi_i2     (deq_yumi_i2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
        return IW'(pc) ^ 32'h0000_0013;
    endfunction

    function automatic logic [MW-1:0] meta_of(input logic [VW-1:0] pc);
        return MW'(pc) * 3 + 1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".deq_v1"}, 64'(deq_v_o1), 64'(q.size() >= 1));
        chk({tag, ".deq_v2"}, 64'(deq_v_o2), 64'(q.size() >= 2));
        chk({tag, ".ready"},  64'(enq_ready_o), 64'(q.size() <= DEPTH - 2));
        chk({tag, ".count"},  64'(dut.w_count), 64'(q.size()));
        if (q.size() >= 1) begin
            chk({tag, ".pc1"},    64'(deq_pc_o1), 64'(q[0].pc));
            chk({tag, ".instr1"}, 64'(deq_instr_o1), 64'(q[0].instr));
            chk({tag, ".exc1"},   64'(deq_exc_o1), 64'(q[0].exc));
            chk({tag, ".meta1"},  64'(deq_metadata_o1), 64'(q[0].meta));
        end
        if (q.size() >= 2) begin
            chk({tag, ".pc2"},    64'(deq_pc_o2), 64'(q[1].pc));
            chk({tag, ".instr2"}, 64'(deq_instr_o2), 64'(q[1].instr));
            chk({tag, ".exc2"},   64'(deq_exc_o2), 64'(q[1].exc));
            chk({tag, ".meta2"},  64'(deq_metadata_o2), 64'(q[1].meta));
        end
    endtask

    // One clock of stimulus; the model decides what the buffer should hold afterwards.
    task automatic step(input string tag, input logic v1, input logic v2, input logic ex1,
                        input logic path, input logic kill, input logic flush,
                        input logic y1, input logic y2, input logic [VW-1:0] pc1);
        int   acc;
        int   dq;
        logic rdy;
        enq_v_i1       = v1;
        enq_v_i2       = v2;
        enq_pc_i1      = pc1;
        enq_pc_i2      = pc1 + 4;
        enq_instr_i1   = instr_of(pc1);
        enq_instr_i2   = instr_of(pc1 + 4);
        enq_exc_i1     = ex1;
        enq_exc_i2     = 1'b0;
        enq_path_i     = path;
        enq_kill_i     = kill;
        enq_metadata_i = meta_of(pc1);
        flush_i        = flush;
        deq_yumi_i1    = y1;
        deq_yumi_i2    = y2;
        rdy = (q.size() <= DEPTH - 2);
        if (flush || kill || !rdy || !v1) acc = 0;
        else if (!v2 || ex1 || path)      acc = 1;
        else                              acc = 2;
        dq = y1 ? (y2 ? 2 : 1) : 0;
        @(posedge clk_i);
        if (flush) begin
            q.delete();
        end else begin
            repeat (dq) void'(q.pop_front());
            if (acc >= 1) q.push_back('{pc: pc1, instr: instr_of(pc1), exc: ex1, meta: meta_of(pc1)});
            if (acc == 2) q.push_back('{pc: pc1 + 4, instr: instr_of(pc1 + 4), exc: 1'b0, meta: meta_of(pc1)});
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with live enqueue/yumi activity that must be ignored.
        reset_n_i = 1'b0;
        flush_i = 1'b0; enq_v_i1 = 1'b1; enq_v_i2 = 1'b1;
        enq_pc_i1 = VW'(32'h900); enq_pc_i2 = VW'(32'h904);
        enq_instr_i1 = '0; enq_instr_i2 = '0; enq_exc_i1 = 1'b0; enq_exc_i2 = 1'b0;
        enq_path_i = 1'b0; enq_kill_i = 1'b0; enq_metadata_i = '0;
        deq_yumi_i1 = 1'b1; deq_yumi_i2 = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset.deq_v1", 64'(deq_v_o1), 64'd0);
        chk("reset.deq_v2", 64'(deq_v_o2), 64'd0);
        chk("reset.count",  64'(dut.w_count), 64'd0);
        reset_n_i = 1'b1;
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, '0);

        step("pair100", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h100));
        chk("pair100.pc1_const", 64'(deq_pc_o1), 64'h100);
        chk("pair100.pc2_const", 64'(deq_pc_o2), 64'h104);
        step("drain100", 0, 0, 0, 0, 0, 0, 1, 1, '0);

        step("path200", 1, 1, 0, 1, 0, 0, 0, 0, VW'(32'h200));
        chk("path200.v2_const", 64'(deq_v_o2), 64'd0);
        step("exc240", 1, 1, 1, 0, 0, 0, 1, 0, VW'(32'h240));
        step("yumi2_only", 0, 0, 0, 0, 0, 0, 0, 1, '0);
        step("kill280", 1, 1, 0, 0, 1, 0, 1, 0, VW'(32'h280));

        step("fill300", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h300));
        step("fill310", 1, 1, 0, 1, 0, 0, 0, 0, VW'(32'h310));
        chk("count3.ready_const", 64'(enq_ready_o), 64'd0);
        step("full320", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h320));
        step("pop1", 0, 0, 0, 0, 0, 0, 1, 0, '0);
        step("fill330", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h330));
        chk("count4.ready_const", 64'(enq_ready_o), 64'd0);
        step("full340", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h340));

        step("deq2_enq350", 1, 1, 0, 0, 0, 0, 1, 1, VW'(32'h350));
        chk("deq2.ready_const", 64'(enq_ready_o), 64'd1);

        step("fill360", 1, 1, 0, 1, 0, 0, 0, 0, VW'(32'h360));
        step("flush370", 1, 1, 0, 0, 0, 1, 1, 0, VW'(32'h370));
        chk("flush.deq_v1_const", 64'(deq_v_o1), 64'd0);
        step("post_flush", 0, 0, 0, 0, 0, 0, 0, 0, '0);

        step("stream0", 1, 1, 0, 0, 0, 0, 0, 0, VW'(32'h1000));
        for (int i = 1; i < 10; i++) begin
            step($sformatf("stream%0d", i), 1, 1, 0, 0, 0, 0, 1, 1, VW'(32'h1000 + i * 8));
        end
        step("stream_drain", 0, 0, 0, 0, 0, 0, 1, 1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_fe_dual_fetch_buffer.md
BP_FE_DUAL_FETCH_BUFFER -- requirements
Module: bp_fe_dual_fetch_buffer

Interface
REQ-001 Parameters SHALL be: bp_params_p, default e_bp_default_cfg, core config; depth_p, default 4, entry count, power of two and at least 2.
REQ-002 clk_i  input  1  sole clock, rising edge.
REQ-003 reset_n_i  input  1  reset, synchronous and active-low.
REQ-004 flush_i  input  1  backend redirect; discard all entries.
REQ-005 enq_v_i1, enq_v_i2  input  1 each  IF2 slot valid (fetch_instr_v from pc_gen stage).
REQ-006 enq_pc_i1, enq_pc_i2  input  vaddr_width_p each  slot PCs.
REQ-007 enq_instr_i1, enq_instr_i2  input  instr_width_gp each  slot instructions.
REQ-008 enq_exc_i1, enq_exc_i2  input  1 each  slot fetch exception.
REQ-009 enq_path_i  input  1  slot 1 redirects control flow (taken branch/jump); drop slot 2.
REQ-010 enq_kill_i  input  1  pc_gen override (ovr) this cycle; squash whole pair.
REQ-011 enq_metadata_i  input  branch_metadata_fwd_width_p  pair branch metadata.
REQ-012 enq_ready_o  output  1  at least two free entries.
REQ-013 deq_v_o1, deq_v_o2  output  1 each  head and head+1 valid.
REQ-014 deq_pc_o1/o2, deq_instr_o1/o2, deq_exc_o1/o2, deq_metadata_o1/o2  output  widths as enqueue  head entries.
REQ-015 deq_yumi_i1, deq_yumi_i2  input  1 each  backend consumes head / head+1.

Function
REQ-016 Accepted-pair count SHALL be: 0 if flush_i, enq_kill_i, ~enq_ready_o or ~enq_v_i1; else 1 if ~enq_v_i2, enq_exc_i1 or enq_path_i; else 2.
REQ-017 Slot 1 SHALL always be written before slot 2, at wr_ptr and wr_ptr+1 (mod depth_p).
REQ-018 Both entries of a pair SHALL store the same enq_metadata_i.
REQ-019 enq_ready_o SHALL equal (count <= depth_p-2), evaluated on registered count, with no credit for same-cycle dequeue.
REQ-020 deq_v_o1 = (count >= 1); deq_v_o2 = (count >= 2); outputs driven from storage only, so enqueue-to-dequeue latency is 1 cycle minimum, with no bypass.
REQ-021 Dequeue count SHALL be yumi1 + (yumi1 & yumi2); yumi2 without yumi1 is ignored; yumi on an invalid slot is a protocol error, flagged by assertion.
REQ-022 rd_ptr and wr_ptr SHALL be log2(depth_p) bits, wrap modulo depth_p; count is log2(depth_p)+1 bits, next = count + enq - deq.
REQ-023 Simultaneous enqueue and dequeue SHALL both take effect in the same cycle; count is unchanged for equal amounts.
REQ-024 flush_i SHALL zero count and set rd_ptr = wr_ptr in the next cycle; it overrides enqueue and dequeue in the same cycle.
REQ-025 An exception entry SHALL dequeue like a normal entry; the backend drops younger entries via flush_i.
REQ-026 Storage contents SHALL NOT be reset; only pointers and count reset.

Reset
REQ-027 When reset_n_i is low at a rising edge, rd_ptr, wr_ptr and count SHALL be 0.
REQ-028 During and after reset: deq_v_o1 = deq_v_o2 = 0 and enq_ready_o = 1 (the latter with reset deasserted).
REQ-029 Enqueue and yumi inputs SHALL be ignored while reset_n_i is low.

Structure
REQ-030 The entry struct {pc, instr, exc, metadata} SHALL be declared by a new macro bp_fe_fetch_entry_s in bp_fe_pkg/bp_fe_defines.
REQ-031 Storage SHALL be a depth_p flop array with 2 write ports and 2 read ports.
REQ-032 Pointer/count arithmetic SHALL reside in one sub-module, bp_fe_fetch_buffer_ptr (inputs enq count, deq count, flush; outputs ptrs, count).

Verification
REQ-033 Reset, then enq pair PC 0x100/0x104 -> next cycle deq_v_o1 = deq_v_o2 = 1, deq_pc_o1 = 0x100, deq_pc_o2 = 0x104, count 2.
REQ-034 enq_path_i = 1 with pair 0x200/0x204 -> only 0x200 enqueued; deq_v_o2 = 0.
REQ-035 depth_p = 4: enqueue pairs until full with no yumi -> enq_ready_o = 0 at count 3 and 4; extra enq_v_i1 ignored, no overwrite.
REQ-036 count 4, yumi1 and yumi2 with a new enqueue presented -> enqueue rejected (enq_ready_o = 0); count 2 next cycle, then ready.
REQ-037 Pointer wrap: 10 pairs streamed with simultaneous 2-yumi each cycle -> PCs dequeued in exact enqueue order across wrap.
REQ-038 flush_i asserted together with an enqueue and yumi at count 3 -> count 0 next cycle; deq_v_o1 = 0; no entry from that cycle visible.
